alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu.sv | 27 ++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcodes, FSM state type and per-opcode execute latency shared by the ALU
// arbiter and the ALU datapath.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    function automatic int op_latency(input logic [1:0] op, input int mul_cycles,
                                      input int div_cycles);
        case (op)
            OP_MUL:  return mul_cycles;
            OP_DIV:  return div_cycles;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath: unsigned add/sub/mul/div, truncated to WIDTH.
// A zero divisor gives an undefined quotient; callers must mask it.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             ready
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_MUL: result = a * b;
            OP_DIV: result = a / b;
        endcase
    end

    assign ready = 1'b1;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one multicycle ALU between two valid/ready requesters;
// operands are held stable for the opcode latency so MUL/DIV can be multicycle paths.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err
);

    localparam int MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    state_t           state, state_nxt;
    logic             last_grant, owner;
    logic [WIDTH-1:0] a_q, b_q, res_q, alu_res;
    logic [1:0]       op_q;
    logic             err_q;
    logic [CW-1:0]    cnt, cnt_load;
    logic             grant0, grant1, zdiv;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [1:0]       sel_op;
    logic             alu_unused_ready;

    // On a tie the port that did not win last time gets the grant.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;
    assign sel_op = grant1 ? req1_op : req0_op;

    // A zero divide finishes in one cycle whatever DIV_CYCLES is.
    always_comb begin
        if (sel_op == OP_DIV && sel_b == '0)
            cnt_load = '0;
        else
            cnt_load = CW'(op_latency(sel_op, MUL_CYCLES, DIV_CYCLES) - 1);
    end

    assign zdiv = (op_q == OP_DIV) && (b_q == '0);

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_res),
        .ready  (alu_unused_ready)
    );

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req0_ready = grant0 && !rst;
                req1_ready = grant1 && !rst;
                if (grant0 || grant1) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (cnt == '0) state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                if (owner ? rsp1_ready : rsp0_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            cnt        <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        op_q       <= sel_op;
                        owner      <= grant1;
                        last_grant <= grant1;
                        cnt        <= cnt_load;
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        res_q <= zdiv ? '0 : alu_res;
                        err_q <= zdiv;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_result = res_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed checks of alu_arbiter against a behavioural model of
// arithmetic, latency and round-robin grant order.
module tb_alu_arbiter;

    localparam int MULC = 2;
    localparam int DIVC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;

    int passed = 0;
    int total  = 0;
    logic model_last;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            default: return (b == 0) ? 32'd0 : a / b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
        if (op == 2'd2) return MULC;
        if (op == 2'd3) return (b == 0) ? 1 : DIVC;
        return 1;
    endfunction

    // Stimulus only: issue one op on a port, measure latency, consume response.
    task automatic run_op(input int port, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output logic [31:0] res,
                          output logic err, output logic ok);
        int n;
        ok = 1'b1; n = 0; lat = 0; res = '0; err = 1'b0;
        @(negedge clk);
        if (port == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        else           begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        #1;
        while (!(port == 0 ? req0_ready : req1_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            ok = 1'b0; req0_valid = 0; req1_valid = 0;
            return;
        end
        model_last = port[0];
        @(negedge clk);
        if (port == 0) req0_valid = 0; else req1_valid = 0;
        while (!(port == 0 ? rsp0_valid : rsp1_valid) && lat < 64) begin
            @(negedge clk); lat++;
        end
        if (lat >= 64) begin ok = 1'b0; return; end
        res = rsp_result;
        err = rsp_err;
        if (port == 0) rsp0_ready = 1; else rsp1_ready = 1;
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_reset;
        rst = 1; req0_valid = 1; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        model_last = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (req0_ready !== 1'b0) $display("FAIL reset_ready actual=%b required=0", req0_ready);
        else passed++;
        @(negedge clk);
        rst = 0; req0_valid = 0;
        #1;
        total++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err} !== 5'b0 || rsp_result !== 32'd0)
            $display("FAIL reset_idle actual=%b/%h required=0/0",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err}, rsp_result);
        else passed++;
    endtask

    task automatic test_add;
        int lat; logic [31:0] res; logic err, ok;
        run_op(0, 2'd0, 32'd5, 32'd7, lat, res, err, ok);
        total++;
        if (!ok || lat !== 1 || res !== 32'd12 || err !== 1'b0)
            $display("FAIL add_5_7 actual=ok%b lat%0d res%h err%b required=ok1 lat1 res0000000c err0",
                     ok, lat, res, err);
        else passed++;
    endtask

    task automatic test_contention;
        int g, exp_g, n;
        logic [31:0] exp_r;
        @(negedge clk);
        req0_valid = 1; req0_op = 2'd0; req0_a = 32'd5; req0_b = 32'd7;
        req1_valid = 1; req1_op = 2'd1; req1_a = 32'd3; req1_b = 32'd5;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = model_last ? 0 : 1;
            g = req1_ready ? 1 : 0;
            total++;
            if ((req0_ready ^ req1_ready) !== 1'b1 || g != exp_g)
                $display("FAIL contention_grant%0d actual=%b%b required_port=%0d",
                         k, req1_ready, req0_ready, exp_g);
            else passed++;
            model_last = exp_g[0];
            exp_r = (exp_g == 0) ? model_res(2'd0, 5, 7) : model_res(2'd1, 3, 5);
            @(negedge clk);
            n = 0;
            while (!(g == 0 ? rsp0_valid : rsp1_valid) && n < 64) begin @(negedge clk); n++; end
            total++;
            if (n >= 64 || rsp_result !== exp_r || (g == 0 ? rsp1_valid : rsp0_valid) !== 1'b0)
                $display("FAIL contention_result%0d actual=%h required=%h", k, rsp_result, exp_r);
            else passed++;
            if (g == 0) rsp0_ready = 1; else rsp1_ready = 1;
            @(negedge clk);
            rsp0_ready = 0; rsp1_ready = 0;
            if (k == 3) begin req0_valid = 0; req1_valid = 0; end
            #1;
        end
    endtask

    task automatic test_mul_div;
        int lat; logic [31:0] res; logic err, ok;
        run_op(1, 2'd2, 32'h0001_0000, 32'h0001_0000, lat, res, err, ok);
        total++;
        if (!ok || lat !== MULC || res !== 32'd0 || err !== 1'b0)
            $display("FAIL mul_trunc actual=lat%0d res%h err%b required=lat%0d res0 err0",
                     lat, res, err, MULC);
        else passed++;
        run_op(0, 2'd3, 32'd100, 32'd7, lat, res, err, ok);
        total++;
        if (!ok || lat !== DIVC || res !== 32'd14 || err !== 1'b0)
            $display("FAIL div_100_7 actual=lat%0d res%h err%b required=lat%0d res0000000e err0",
                     lat, res, err, DIVC);
        else passed++;
    endtask

    task automatic test_zero_div;
        int lat; logic [31:0] res; logic err, ok;
        run_op(0, 2'd3, 32'd9, 32'd0, lat, res, err, ok);
        total++;
        if (!ok || lat !== 1 || res !== 32'd0 || err !== 1'b1)
            $display("FAIL div_zero actual=lat%0d res%h err%b required=lat1 res0 err1", lat, res, err);
        else passed++;
        run_op(1, 2'd3, 32'd9, 32'd3, lat, res, err, ok);
        total++;
        if (!ok || lat !== DIVC || res !== 32'd3 || err !== 1'b0)
            $display("FAIL div_after_zero actual=lat%0d res%h err%b required=lat%0d res3 err0",
                     lat, res, err, DIVC);
        else passed++;
    endtask

    task automatic test_backpressure;
        int n, bad;
        logic [31:0] exp_r, a, b;
        a = $urandom; b = $urandom;
        exp_r = model_res(2'd2, a, b);
        @(negedge clk);
        req1_valid = 1; req1_op = 2'd2; req1_a = a; req1_b = b;
        #1;
        total++;
        if (req1_ready !== 1'b1) $display("FAIL bp_accept actual=%b required=1", req1_ready);
        else passed++;
        model_last = 1'b1;
        @(negedge clk);
        req1_valid = 0;
        req0_valid = 1; req0_op = 2'd0; req0_a = 32'd1; req0_b = 32'd2;
        n = 0;
        while (!rsp1_valid && n < 64) begin @(negedge clk); n++; end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rsp1_valid !== 1'b1 || rsp_result !== exp_r || req0_ready !== 1'b0 || rsp0_valid !== 1'b0)
                bad++;
            @(negedge clk);
        end
        total++;
        if (n >= 64 || bad != 0)
            $display("FAIL bp_hold actual_bad_cycles=%0d result=%h required_bad=0 result=%h",
                     bad, rsp_result, exp_r);
        else passed++;
        rsp1_ready = 1;
        @(negedge clk);
        rsp1_ready = 0;
        #1;
        total++;
        if (req0_ready !== 1'b1) $display("FAIL bp_release_grant actual=%b required=1", req0_ready);
        else passed++;
        model_last = 1'b0;
        @(negedge clk);
        req0_valid = 0;
        n = 0;
        while (!rsp0_valid && n < 64) begin @(negedge clk); n++; end
        total++;
        if (n >= 64 || rsp_result !== 32'd3)
            $display("FAIL bp_post_result actual=%h required=00000003", rsp_result);
        else passed++;
        rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0;
    endtask

    task automatic test_reset_mid_op;
        int seen, n;
        @(negedge clk);
        req0_valid = 1; req0_op = 2'd3; req0_a = 32'd100; req0_b = 32'd7;
        #1;
        total++;
        if (req0_ready !== 1'b1) $display("FAIL rmid_accept actual=%b required=1", req0_ready);
        else passed++;
        @(negedge clk);
        req0_valid = 0;
        rst = 1;
        model_last = 1'b1;
        @(negedge clk);
        rst = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (rsp0_valid || rsp1_valid) seen++;
            @(negedge clk);
        end
        rsp0_ready = 0; rsp1_ready = 0;
        total++;
        if (seen != 0) $display("FAIL rmid_no_rsp actual_rsp_cycles=%0d required=0", seen);
        else passed++;
        req0_valid = 1; req0_op = 2'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1; req1_op = 2'd0; req1_a = 32'd2; req1_b = 32'd2;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL rmid_tie actual=%b%b required=01", req1_ready, req0_ready);
        else passed++;
        model_last = 1'b0;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        n = 0;
        while (!rsp0_valid && n < 64) begin @(negedge clk); n++; end
        rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0;
    endtask

    task automatic test_random;
        int lat, port; logic [31:0] res, a, b; logic err, ok; logic [1:0] op;
        for (int i = 0; i < 24; i++) begin
            port = $urandom_range(0, 1);
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 :
                (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op(port, op, a, b, lat, res, err, ok);
            total++;
            if (!ok || res !== model_res(op, a, b) || err !== (op == 2'd3 && b == 0) ||
                lat != model_lat(op, b))
                $display("FAIL rand%0d op%0d a=%h b=%h actual=res%h err%b lat%0d required=res%h err%b lat%0d",
                         i, op, a, b, res, err, lat, model_res(op, a, b),
                         (op == 2'd3 && b == 0), model_lat(op, b));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_contention();
        test_mul_div();
        test_zero_div();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
